status_led_array: RTL and testbench

//   Parametrised multi-channel status-LED driver, successor to the per-LED activity visualizer instances.
//   One instance drives every board status LED (booted, Eth, flash, USB0/1, PS2, HDMI, QSPI, GPU, I2S).

---
 rtl/status_led_array.sv | 168 ++++++++++++++++
 tb/tb_status_led_array.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/status_led_array.sv
// -----------------------------------------------------------------------------
// status_led_array
//   Multi-channel status-LED driver. Each channel has a run-time mode
//   (off, on, activity-stretch, blink). The PWM brightness, the blink
//   timebase and the output polarity are shared by every channel.
//
// Ports
//   clk         system clock
//   nreset      asynchronous reset, active-low
//   activity    per-channel activity strobe, synchronous to clk
//   mode        2 bits per channel: 00 off, 01 on, 10 activity, 11 blink
//   brightness  global PWM duty: 0 = dark, all-ones = fully on
//   busy        per-channel stretch counter non-zero (combinational from counter)
//   led         registered LED drive, inverted when ACTIVE_LOW = 1
// -----------------------------------------------------------------------------
module status_led_array #(
  parameter int CHANNELS   = 10,
  parameter int MIN_CLK    = 100000,
  parameter int BLINK_CLK  = 12500000,
  parameter int PWM_BITS   = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic [CHANNELS-1:0]     activity,
  input  logic [2*CHANNELS-1:0]   mode,
  input  logic [PWM_BITS-1:0]     brightness,
  output logic [CHANNELS-1:0]     busy,
  output logic [CHANNELS-1:0]     led
);

  localparam int CNT_W = $clog2(MIN_CLK + 1);
  localparam int BLK_W = (BLINK_CLK > 1) ? $clog2(BLINK_CLK) : 1;

  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(MIN_CLK);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [BLK_W-1:0] BLINK_LAST   = BLK_W'(BLINK_CLK - 1);
  localparam logic [BLK_W-1:0] BLK_ZERO     = {BLK_W{1'b0}};
  localparam logic [BLK_W-1:0] BLK_ONE      = BLK_W'(1);
  localparam logic [PWM_BITS-1:0] PWM_ZERO  = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);
  localparam logic POLARITY                 = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'b00,
    MODE_ON       = 2'b01,
    MODE_ACTIVITY = 2'b10,
    MODE_BLINK    = 2'b11
  } led_mode_e;

  // Reject illegal parameterisations at elaboration time.
  if (MIN_CLK < 1) begin : g_bad_min_clk
    $error("status_led_array: MIN_CLK must be >= 1");
  end
  if (BLINK_CLK < 1) begin : g_bad_blink_clk
    $error("status_led_array: BLINK_CLK must be >= 1");
  end
  if ((CHANNELS < 1) || (CHANNELS > 32)) begin : g_bad_channels
    $error("status_led_array: CHANNELS must be in 1..32");
  end
  if (PWM_BITS < 1) begin : g_bad_pwm_bits
    $error("status_led_array: PWM_BITS must be >= 1");
  end

  logic [CHANNELS-1:0] act_q_r;
  logic [CNT_W-1:0]    stretch_cnt_r [CHANNELS];
  logic [BLK_W-1:0]    blink_cnt_r;
  logic                blink_phase_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic                pwm_on_s;
  logic [CHANNELS-1:0] busy_s;
  logic [CHANNELS-1:0] raw_s;
  logic [CHANNELS-1:0] led_r;

  // Activity sample register: one cycle of alignment before the stretch stage.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      act_q_r <= {CHANNELS{1'b0}};
    end else begin
      act_q_r <= activity;
    end
  end

  // Per-channel stretch counters; a new strobe reloads the full length so
  // back-to-back strobes merge into one continuous busy window.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        stretch_cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (act_q_r[i]) begin
          stretch_cnt_r[i] <= STRETCH_LOAD;
        end else if (stretch_cnt_r[i] != CNT_ZERO) begin
          stretch_cnt_r[i] <= stretch_cnt_r[i] - CNT_ONE;
        end else begin
          stretch_cnt_r[i] <= CNT_ZERO;
        end
      end
    end
  end

  // Busy flags decoded straight from the counters.
  always_comb begin
    busy_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      busy_s[i] = (stretch_cnt_r[i] != CNT_ZERO);
    end
  end

  assign busy = busy_s;

  // Shared blink timebase; free-running so mode changes never disturb it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      blink_cnt_r   <= BLK_ZERO;
      blink_phase_r <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r   <= BLK_ZERO;
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_cnt_r   <= blink_cnt_r + BLK_ONE;
      blink_phase_r <= blink_phase_r;
    end
  end

  // Free-running PWM ramp, wraps naturally at 2^PWM_BITS.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pwm_cnt_r <= PWM_ZERO;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
    end
  end

  // All-ones brightness forces full duty; the compare alone would leave one dark slot.
  always_comb begin
    pwm_on_s = (pwm_cnt_r < brightness) | (&brightness);
  end

  // Per-channel source select by mode.
  always_comb begin
    raw_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      case (led_mode_e'(mode[2*i +: 2]))
        MODE_OFF:      raw_s[i] = 1'b0;
        MODE_ON:       raw_s[i] = 1'b1;
        MODE_ACTIVITY: raw_s[i] = busy_s[i];
        MODE_BLINK:    raw_s[i] = blink_phase_r;
        default:       raw_s[i] = 1'b0;
      endcase
    end
  end

  // Registered LED drive so the pins never see combinational glitches.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      led_r <= {CHANNELS{POLARITY}};
    end else begin
      led_r <= (raw_s & {CHANNELS{pwm_on_s}}) ^ {CHANNELS{POLARITY}};
    end
  end

  assign led = led_r;

endmodule

// File: tb/tb_status_led_array.sv
// -----------------------------------------------------------------------------
// tb_status_led_array
//   Directed bench for status_led_array. Two instances share the same
//   stimulus: one active-high, one active-low, so every expected LED value
//   is checked in both polarities. Expected values are computed from the
//   cycle number since reset release and pushed to a scoreboard queue,
//   then popped and compared one per clock.
// -----------------------------------------------------------------------------
module tb_status_led_array;

  logic       clk = 1'b0;
  logic       nreset;
  logic [3:0] activity;
  logic [7:0] mode;
  logic [3:0] brightness;
  logic [3:0] busy0;
  logic [3:0] led0;
  logic [3:0] busy1;
  logic [3:0] led1;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  typedef struct {
    string      tag;
    logic [3:0] led;
    logic [3:0] busy;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  status_led_array #(
    .CHANNELS(4), .MIN_CLK(8), .BLINK_CLK(4), .PWM_BITS(4), .ACTIVE_LOW(0)
  ) dut_hi (
    .clk(clk), .nreset(nreset), .activity(activity), .mode(mode),
    .brightness(brightness), .busy(busy0), .led(led0)
  );

  status_led_array #(
    .CHANNELS(4), .MIN_CLK(8), .BLINK_CLK(4), .PWM_BITS(4), .ACTIVE_LOW(1)
  ) dut_lo (
    .clk(clk), .nreset(nreset), .activity(activity), .mode(mode),
    .brightness(brightness), .busy(busy1), .led(led1)
  );

  // Number of rising edges since reset release.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Blink phase seen on led after edge n (phase toggles every 4 edges, registered once).
  function automatic logic blink_at(input int n);
    return ((((n - 1) / 4) % 2) == 1) ? 1'b1 : 1'b0;
  endfunction

  // PWM gate seen on led after edge n for a given brightness.
  function automatic logic pwm_at(input int n, input logic [3:0] br);
    return ((((n - 1) % 16) < int'(br)) || (br == 4'hF)) ? 1'b1 : 1'b0;
  endfunction

  task automatic check(input string tag, input logic [3:0] el, input logic [3:0] eb);
    n_assert++;
    assert (led0 === el) else begin
      n_fail++;
      $error("FAIL %s led_hi observed=%b expected=%b", tag, led0, el);
    end
    n_assert++;
    assert (led1 === ~el) else begin
      n_fail++;
      $error("FAIL %s led_lo observed=%b expected=%b", tag, led1, ~el);
    end
    n_assert++;
    assert (busy0 === eb) else begin
      n_fail++;
      $error("FAIL %s busy_hi observed=%b expected=%b", tag, busy0, eb);
    end
    n_assert++;
    assert (busy1 === eb) else begin
      n_fail++;
      $error("FAIL %s busy_lo observed=%b expected=%b", tag, busy1, eb);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] el, input logic [3:0] eb);
    exp_t e;
    e.tag  = tag;
    e.led  = el;
    e.busy = eb;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_check();
    exp_t e;
    step();
    e = sbq.pop_front();
    check(e.tag, e.led, e.busy);
  endtask

  task automatic drain();
    while (sbq.size() > 0) pop_check();
  endtask

  initial begin
    nreset     = 1'b0;
    activity   = 4'b0000;
    mode       = 8'b10_10_10_10;
    brightness = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_initial", 4'b0000, 4'b0000);
    nreset = 1'b1;

    // Single activity pulse on ch0 at edge k; other channels off.
    mode     = 8'b00_00_00_10;
    activity = 4'b0001;
    for (int d = 0; d <= 10; d++) begin
      push("pulse", {3'b000, (d >= 2 && d <= 9)}, {3'b000, (d >= 1 && d <= 8)});
    end
    pop_check();
    activity = 4'b0000;
    drain();

    // Pulses at k and k+5 merge into one stretch ending 8 cycles after k+5.
    activity = 4'b0001;
    for (int d = 0; d <= 16; d++) begin
      push("retrigger", {3'b000, (d >= 2 && d <= 14)}, {3'b000, (d >= 1 && d <= 13)});
    end
    pop_check();
    activity = 4'b0000;
    repeat (4) pop_check();
    activity = 4'b0001;
    pop_check();
    activity = 4'b0000;
    drain();

    // Reset asserted mid-stretch clears outputs immediately.
    activity = 4'b0001;
    step();
    activity = 4'b0000;
    step();
    step();
    check("pre_reset", 4'b0001, 4'b0001);
    nreset = 1'b0;
    #1;
    check("reset_async", 4'b0000, 4'b0000);
    step();
    check("reset_hold", 4'b0000, 4'b0000);
    step();
    check("reset_hold", 4'b0000, 4'b0000);
    nreset = 1'b1;
    mode   = 8'b10_10_10_10;
    repeat (4) push("post_reset", 4'b0000, 4'b0000);
    drain();

    // ch0 activity (idle), ch1 blink, ch2 on, ch3 off.
    mode = 8'b00_01_11_10;
    for (int i = 1; i <= 20; i++) begin
      push("modes", {1'b0, 1'b1, blink_at(cyc + i), 1'b0}, 4'b0000);
    end
    drain();

    // Brightness: 4/16 duty, then 0, then full.
    mode       = 8'b01_01_01_01;
    brightness = 4'd4;
    for (int i = 1; i <= 32; i++) begin
      push("pwm_4", {4{pwm_at(cyc + i, 4'd4)}}, 4'b0000);
    end
    drain();
    brightness = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      push("pwm_0", {4{pwm_at(cyc + i, 4'd0)}}, 4'b0000);
    end
    drain();
    brightness = 4'hF;
    for (int i = 1; i <= 16; i++) begin
      push("pwm_full", 4'b1111, 4'b0000);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
